// File: rtl/nanorv32_mem_arbiter_pkg.sv
// Shared constants, decode payload and address decode helper for the nanorv32 code/data bank arbiter.
package nanorv32_mem_arbiter_pkg;

    localparam int unsigned NRV32_ARB_AW = 15;
    localparam int unsigned NRV32_DATA_W = 32;
    localparam int unsigned NRV32_BE_W   = 4;

    localparam bit NRV32_ARB_REQ_CODE = 1'b0;
    localparam bit NRV32_ARB_REQ_DATA = 1'b1;
    localparam bit NRV32_ROM_BANK     = 1'b0;
    localparam bit NRV32_RAM_BANK     = 1'b1;

    typedef struct packed {
        logic err;
        logic bank;
    } dec_t;

    // Anything above the two banks is a decode error; otherwise bit aw picks the bank.
    function automatic dec_t decode(input logic [31:0] addr, input int unsigned aw);
        dec_t d;
        d.err  = (addr >> (aw + 1)) != 32'h0;
        d.bank = addr[5'(aw)];
        return d;
    endfunction

endpackage

// File: rtl/nanorv32_bank_arb.sv
// Per-bank arbiter: picks one of code/data each cycle, drives the bank, registers the owner.
// Same-bank conflicts alternate when NRV32_ARB_ROUND_ROBIN_EN is defined, else data always wins.
module nanorv32_bank_arb
    import nanorv32_mem_arbiter_pkg::*;
#(
    parameter int unsigned WAW = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  code_req,
    input  logic                  data_req,
    input  logic [WAW-1:0]        code_word,
    input  logic [WAW-1:0]        data_word,
    input  logic [NRV32_BE_W-1:0] data_we,
    output logic                  grant_code_c,
    output logic                  grant_data_c,
    output logic [WAW-1:0]        addr_c,
    output logic [NRV32_BE_W-1:0] we_c,
    output logic                  own_code,
    output logic                  own_data
);

    logic           favor_code;
    logic           winner_c;
    logic [WAW-1:0] addr_q;

`ifdef NRV32_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Last winner; reset value makes code the favoured side on the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= NRV32_ARB_REQ_DATA;
        end else if (grant_data_c) begin
            last_q <= NRV32_ARB_REQ_DATA;
        end else if (grant_code_c) begin
            last_q <= NRV32_ARB_REQ_CODE;
        end
    end

    assign favor_code = (last_q == NRV32_ARB_REQ_DATA);
`else
    assign favor_code = 1'b0;
`endif

    // Winner select and bank drive; an idle bank keeps its previous word address.
    always_comb begin
        winner_c     = NRV32_ARB_REQ_CODE;
        grant_code_c = 1'b0;
        grant_data_c = 1'b0;
        addr_c       = addr_q;
        we_c         = '0;
        if (data_req && !(code_req && favor_code)) begin
            winner_c = NRV32_ARB_REQ_DATA;
        end
        grant_data_c = data_req && (winner_c == NRV32_ARB_REQ_DATA);
        grant_code_c = code_req && (winner_c == NRV32_ARB_REQ_CODE);
        if (grant_data_c) begin
            addr_c = data_word;
            we_c   = data_we;
        end else if (grant_code_c) begin
            addr_c = code_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_code <= 1'b0;
            own_data <= 1'b0;
            addr_q   <= '0;
        end else begin
            own_code <= grant_code_c;
            own_data <= grant_data_c;
            addr_q   <= addr_c;
        end
    end

endmodule

// File: rtl/nanorv32_mem_arbiter.sv
// Shares the ROM (bank 0) and RAM (bank 1) between the nanorv32 code and data ports.
// Optional NRV32_ARB_ROUND_ROBIN_EN alternates same-bank winners instead of data-first priority.
module nanorv32_mem_arbiter
    import nanorv32_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = NRV32_ARB_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_codemem_valid,
    input  logic [31:0]             cpu_codemem_addr,
    output logic [NRV32_DATA_W-1:0] codemem_cpu_rdata,
    output logic                    codemem_cpu_ready,
    input  logic                    cpu_datamem_valid,
    input  logic [31:0]             cpu_datamem_addr,
    input  logic [NRV32_DATA_W-1:0] cpu_datamem_wdata,
    input  logic [NRV32_BE_W-1:0]   cpu_datamem_bytesel,
    output logic [NRV32_DATA_W-1:0] datamem_cpu_rdata,
    output logic                    datamem_cpu_ready,
    output logic [AW-3:0]           bank0_addr,
    output logic [NRV32_BE_W-1:0]   bank0_we,
    output logic [NRV32_DATA_W-1:0] bank0_din,
    input  logic [NRV32_DATA_W-1:0] bank0_dout,
    output logic [AW-3:0]           bank1_addr,
    output logic [NRV32_BE_W-1:0]   bank1_we,
    output logic [NRV32_DATA_W-1:0] bank1_din,
    input  logic [NRV32_DATA_W-1:0] bank1_dout,
    output logic                    arb_err
);

    localparam int unsigned WAW = AW - 2;

    dec_t       code_dec;
    dec_t       data_dec;
    logic       code_act;
    logic       data_act;
    logic       data_wr;
    logic [1:0] code_req;
    logic [1:0] data_req;
    logic [1:0] grant_code;
    logic [1:0] grant_data;
    logic [1:0] own_code;
    logic [1:0] own_data;

    assign code_dec = decode(cpu_codemem_addr, AW);
    assign data_dec = decode(cpu_datamem_addr, AW);

    // A requester whose ready is showing still holds valid for the finished access.
    assign code_act = cpu_codemem_valid && !codemem_cpu_ready;
    assign data_act = cpu_datamem_valid && !datamem_cpu_ready;
    assign data_wr  = |cpu_datamem_bytesel;

    assign code_req[NRV32_ROM_BANK] = code_act && !code_dec.err && (code_dec.bank == NRV32_ROM_BANK);
    assign code_req[NRV32_RAM_BANK] = code_act && !code_dec.err && (code_dec.bank == NRV32_RAM_BANK);
    assign data_req[NRV32_ROM_BANK] = data_act && !data_dec.err && (data_dec.bank == NRV32_ROM_BANK);
    assign data_req[NRV32_RAM_BANK] = data_act && !data_dec.err && (data_dec.bank == NRV32_RAM_BANK);

    assign bank0_din = cpu_datamem_wdata;
    assign bank1_din = cpu_datamem_wdata;

    // The ROM bank never sees write enables; a write there still completes but flags arb_err.
    nanorv32_bank_arb #(.WAW(WAW)) u_rom_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_req     (code_req[NRV32_ROM_BANK]),
        .data_req     (data_req[NRV32_ROM_BANK]),
        .code_word    (cpu_codemem_addr[AW-1:2]),
        .data_word    (cpu_datamem_addr[AW-1:2]),
        .data_we      ('0),
        .grant_code_c (grant_code[NRV32_ROM_BANK]),
        .grant_data_c (grant_data[NRV32_ROM_BANK]),
        .addr_c       (bank0_addr),
        .we_c         (bank0_we),
        .own_code     (own_code[NRV32_ROM_BANK]),
        .own_data     (own_data[NRV32_ROM_BANK])
    );

    nanorv32_bank_arb #(.WAW(WAW)) u_ram_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_req     (code_req[NRV32_RAM_BANK]),
        .data_req     (data_req[NRV32_RAM_BANK]),
        .code_word    (cpu_codemem_addr[AW-1:2]),
        .data_word    (cpu_datamem_addr[AW-1:2]),
        .data_we      (cpu_datamem_bytesel),
        .grant_code_c (grant_code[NRV32_RAM_BANK]),
        .grant_data_c (grant_data[NRV32_RAM_BANK]),
        .addr_c       (bank1_addr),
        .we_c         (bank1_we),
        .own_code     (own_code[NRV32_RAM_BANK]),
        .own_data     (own_data[NRV32_RAM_BANK])
    );

    // Completion and error pulses land one cycle after the grant (or the decode error).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codemem_cpu_ready <= 1'b0;
            datamem_cpu_ready <= 1'b0;
            arb_err           <= 1'b0;
        end else begin
            codemem_cpu_ready <= code_act && (code_dec.err || (|grant_code));
            datamem_cpu_ready <= data_act && (data_dec.err || (|grant_data));
            arb_err           <= (code_act && code_dec.err) || (data_act && data_dec.err)
                                 || (grant_data[NRV32_ROM_BANK] && data_wr);
        end
    end

    // Read data follows the bank owned last cycle; decode errors own nothing and read zero.
    always_comb begin
        codemem_cpu_rdata = '0;
        datamem_cpu_rdata = '0;
        if (own_code[NRV32_ROM_BANK]) begin
            codemem_cpu_rdata = bank0_dout;
        end else if (own_code[NRV32_RAM_BANK]) begin
            codemem_cpu_rdata = bank1_dout;
        end
        if (own_data[NRV32_ROM_BANK]) begin
            datamem_cpu_rdata = bank0_dout;
        end else if (own_data[NRV32_RAM_BANK]) begin
            datamem_cpu_rdata = bank1_dout;
        end
    end

endmodule

// File: tb/tb_nanorv32_mem_arbiter.sv
// Bench for nanorv32_mem_arbiter: directed scenarios then random traffic against a flat-memory model.
// Honours NRV32_ARB_ROUND_ROBIN_EN so the model matches the build under test.
module tb_nanorv32_mem_arbiter;

    localparam int unsigned AW    = 15;
    localparam int unsigned WAW   = AW - 2;
    localparam int unsigned DEPTH = 1 << WAW;
`ifdef NRV32_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cv, dv;
    logic [31:0]    caddr, daddr, wdata;
    logic [3:0]     bsel;
    logic [31:0]    crdata, drdata;
    logic           cready, dready, arb_err;
    logic [WAW-1:0] b0_addr, b1_addr;
    logic [3:0]     b0_we, b1_we;
    logic [31:0]    b0_din, b1_din, b0_dout, b1_dout;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] ram     [2][DEPTH];
    logic [31:0] ref_mem [2][DEPTH];
    bit          mem_ready = 1'b0;

    // Model state: what the coming cycle must show, plus per-bank history.
    logic           exp_cr = 1'b0, exp_dr = 1'b0, exp_err = 1'b0, exp_drchk = 1'b0;
    logic [31:0]    exp_crdata = '0, exp_drdata = '0;
    logic           code_done = 1'b0, data_done = 1'b0;
    bit             fav_code [2] = '{RR, RR};
    logic [WAW-1:0] last_addr [2];
    bit             last_valid [2] = '{1'b0, 1'b0};
    bit             c_hold = 1'b0, d_hold = 1'b0;
    logic [31:0]    c_hold_addr, d_hold_addr;
    logic [3:0]     d_hold_bsel;

    always #5 clk = ~clk;

    nanorv32_mem_arbiter #(.AW(AW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cpu_codemem_valid   (cv),
        .cpu_codemem_addr    (caddr),
        .codemem_cpu_rdata   (crdata),
        .codemem_cpu_ready   (cready),
        .cpu_datamem_valid   (dv),
        .cpu_datamem_addr    (daddr),
        .cpu_datamem_wdata   (wdata),
        .cpu_datamem_bytesel (bsel),
        .datamem_cpu_rdata   (drdata),
        .datamem_cpu_ready   (dready),
        .bank0_addr          (b0_addr),
        .bank0_we            (b0_we),
        .bank0_din           (b0_din),
        .bank0_dout          (b0_dout),
        .bank1_addr          (b1_addr),
        .bank1_we            (b1_we),
        .bank1_din           (b1_din),
        .bank1_dout          (b1_dout),
        .arb_err             (arb_err)
    );

    function automatic logic [31:0] init_word(input int b, input int i);
        if (b == 0 && i == 0) return 32'h0000_0013;
        return 32'(i * 32'h9E37_79B1) ^ ((b != 0) ? 32'h5A5A_0000 : 32'h0);
    endfunction

    // Two byte-writable synchronous RAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < int'(DEPTH); i++) ram[b][i] = init_word(b, i);
            mem_ready = 1'b1;
        end
        b0_dout <= ram[0][b0_addr];
        b1_dout <= ram[1][b1_addr];
        for (int i = 0; i < 4; i++) begin
            if (b0_we[i]) ram[0][b0_addr][8*i +: 8] = b0_din[8*i +: 8];
            if (b1_we[i]) ram[1][b1_addr][8*i +: 8] = b1_din[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'h0001_0000 + 32'($urandom_range(0, 255) * 4);
        return (32'(r & 1) << 15) | 32'($urandom_range(0, 7) * 4);
    endfunction

    // One clock: check at the falling edge, predict next cycle, advance to just after the rising edge.
    task automatic cycle();
        logic           c_act, d_act, c_err, d_err, c_bank, d_bank, cr, dr, gc, gd;
        logic [WAW-1:0] c_word, d_word, o_addr, e_addr;
        logic [3:0]     o_we, e_we;
        logic           n_cr, n_dr, n_err, n_drchk;
        logic [31:0]    n_crdata, n_drdata;
        @(negedge clk);
        if (rst_n && c_hold) begin
            chk("hold_code_valid", 32'(cv), 32'd1);
            chk("hold_code_addr", caddr, c_hold_addr);
        end
        if (rst_n && d_hold) begin
            chk("hold_data_valid", 32'(dv), 32'd1);
            chk("hold_data_addr", daddr, d_hold_addr);
            chk("hold_data_bsel", 32'(bsel), 32'(d_hold_bsel));
        end
        chk("code_ready", 32'(cready), 32'(exp_cr));
        chk("data_ready", 32'(dready), 32'(exp_dr));
        chk("arb_err", 32'(arb_err), 32'(exp_err));
        if (exp_cr) chk("code_rdata", crdata, exp_crdata);
        if (exp_dr && exp_drchk) chk("data_rdata", drdata, exp_drdata);
        code_done = exp_cr;
        data_done = exp_dr;

        c_act  = cv && !exp_cr;
        d_act  = dv && !exp_dr;
        c_err  = caddr >= 32'h0001_0000;
        d_err  = daddr >= 32'h0001_0000;
        c_bank = caddr[15];
        d_bank = daddr[15];
        c_word = caddr[14:2];
        d_word = daddr[14:2];
        n_cr = c_act && c_err;
        n_dr = d_act && d_err;
        n_err = n_cr || n_dr;
        n_drchk = 1'b1;
        n_crdata = '0;
        n_drdata = '0;
        for (int b = 0; b < 2; b++) begin
            cr = c_act && !c_err && (int'(c_bank) == b);
            dr = d_act && !d_err && (int'(d_bank) == b);
            gd = dr && !(cr && fav_code[b]);
            gc = cr && !gd;
            e_we   = '0;
            e_addr = last_addr[b];
            if (gd) begin
                e_addr   = d_word;
                e_we     = (b == 1) ? bsel : 4'h0;
                n_dr     = 1'b1;
                n_drchk  = (bsel == 4'h0);
                n_drdata = ref_mem[b][d_word];
                if (b == 0 && bsel != 4'h0) n_err = 1'b1;
                if (b == 1 && rst_n)
                    for (int i = 0; i < 4; i++)
                        if (bsel[i]) ref_mem[1][d_word][8*i +: 8] = wdata[8*i +: 8];
            end else if (gc) begin
                e_addr   = c_word;
                n_cr     = 1'b1;
                n_crdata = ref_mem[b][c_word];
            end
            o_addr = (b == 0) ? b0_addr : b1_addr;
            o_we   = (b == 0) ? b0_we : b1_we;
            if (rst_n) begin
                chk((b == 0) ? "bank0_we" : "bank1_we", 32'(o_we), 32'(e_we));
                if (gd || gc || last_valid[b])
                    chk((b == 0) ? "bank0_addr" : "bank1_addr", 32'(o_addr), 32'(e_addr));
                last_addr[b] = e_addr;
                if (gd || gc) last_valid[b] = 1'b1;
                if (RR && gd) fav_code[b] = 1'b1;
                if (RR && gc) fav_code[b] = 1'b0;
            end else begin
                last_valid[b] = 1'b0;
                fav_code[b]   = RR;
            end
        end
        c_hold = rst_n && cv && !exp_cr;
        d_hold = rst_n && dv && !exp_dr;
        c_hold_addr = caddr;
        d_hold_addr = daddr;
        d_hold_bsel = bsel;
        if (!rst_n) {n_cr, n_dr, n_err} = 3'b000;
        @(posedge clk);
        exp_cr = n_cr;
        exp_dr = n_dr;
        exp_err = n_err;
        exp_crdata = n_crdata;
        exp_drdata = n_drdata;
        exp_drchk = n_drchk;
        #1;
    endtask

    task automatic retire();
        if (code_done) cv = 1'b0;
        if (data_done) dv = 1'b0;
    endtask

    initial begin
        logic [31:0] tmp;
        rst_n = 1'b0;
        cv = 1'b0; dv = 1'b0; caddr = '0; daddr = '0; wdata = '0; bsel = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[b][i] = init_word(b, i);

        // Reset state
        cycle(); cycle();
        chk("rst_code_rdata", crdata, 32'h0);
        chk("rst_data_rdata", drdata, 32'h0);
        chk("rst_bank0_we", 32'(b0_we), 32'h0);
        chk("rst_bank1_we", 32'(b1_we), 32'h0);
        rst_n = 1'b1;
        cycle();

        // 1: fetch from ROM word 0
        cv = 1'b1; caddr = 32'h0000_0000;
        cycle();
        chk("t1_ready", 32'(cready), 32'd1);
        chk("t1_rdata", crdata, 32'h0000_0013);
        cycle(); retire();

        // 2: different banks in the same cycle
        cv = 1'b1; caddr = 32'h0000_0100;
        dv = 1'b1; daddr = 32'h0000_8004; bsel = 4'h0;
        #1;
        chk("t2_bank0_addr", 32'(b0_addr), 32'h40);
        chk("t2_bank1_addr", 32'(b1_addr), 32'h1);
        cycle();
        chk("t2_code_ready", 32'(cready), 32'd1);
        chk("t2_data_ready", 32'(dready), 32'd1);
        cycle(); retire();

        // 3: same-bank conflict
        cv = 1'b1; caddr = 32'h0000_8000;
        dv = 1'b1; daddr = 32'h0000_8010; bsel = 4'h0;
        cycle();
        chk("t3_first_data", 32'(dready), 32'(!RR));
        chk("t3_first_code", 32'(cready), 32'(RR));
        cycle(); retire();
        chk("t3_second_code", 32'(cready), 32'(!RR));
        chk("t3_second_data", 32'(dready), 32'(RR));
        cycle(); retire();
        cycle(); retire();

        // 4: byte write to RAM, then fetch it back
        dv = 1'b1; daddr = 32'h0000_8008; bsel = 4'h3; wdata = 32'hAABB_CCDD;
        #1;
        chk("t4_bank1_we", 32'(b1_we), 32'h3);
        chk("t4_bank1_addr", 32'(b1_addr), 32'h2);
        cycle();
        chk("t4_ready", 32'(dready), 32'd1);
        cycle(); retire();
        cv = 1'b1; caddr = 32'h0000_8008;
        tmp = init_word(1, 2);
        cycle();
        chk("t4_readback", crdata, {tmp[31:16], 16'hCCDD});
        cycle(); retire();

        // 5: write to ROM, then an out-of-range read
        dv = 1'b1; daddr = 32'h0000_0010; bsel = 4'hF; wdata = 32'hDEAD_BEEF;
        #1;
        chk("t5_bank0_we", 32'(b0_we), 32'h0);
        cycle();
        chk("t5_rom_ready", 32'(dready), 32'd1);
        chk("t5_rom_err", 32'(arb_err), 32'd1);
        cycle();
        daddr = 32'h0001_0000; bsel = 4'h0;
        cycle();
        chk("t5_dec_ready", 32'(dready), 32'd1);
        chk("t5_dec_err", 32'(arb_err), 32'd1);
        chk("t5_dec_rdata", drdata, 32'h0);
        cycle(); retire();
        cv = 1'b1; caddr = 32'h0000_0010;
        cycle();
        chk("t5_rom_intact", crdata, init_word(0, 4));
        cycle(); retire();

        // 6: reset during the grant cycle
        cv = 1'b1; caddr = 32'h0000_8000;
        #1 rst_n = 1'b0;
        cycle();
        chk("t6_no_ready", 32'(cready), 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("t6_represent", 32'(cready), 32'd1);
        cycle(); retire();

        // Random traffic on both ports
        for (int k = 0; k < 1500; k++) begin
            if (!cv || code_done) begin
                cv = ($urandom_range(0, 3) != 0);
                caddr = rand_addr();
            end
            if (!dv || data_done) begin
                dv = ($urandom_range(0, 3) != 0);
                daddr = rand_addr();
                bsel = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                wdata = $urandom;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
